// File: rtl/sram_bank_req_arb.sv
// Round-robin request front end for one SRAM bank: grants one channel per cycle,
// registers the bank command and steers fixed-latency read data back to the requester.
module sram_bank_req_arb #(
  parameter int CHANNEL    = 8,
  parameter int SEL_WIDTH  = $clog2(CHANNEL),
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arb_en,
  input  logic [CHANNEL-1:0]    req_vld,
  output logic [CHANNEL-1:0]    req_rdy,
  input  logic [CHANNEL-1:0]    req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr [CHANNEL],
  input  logic [DATA_WIDTH-1:0] req_wdata [CHANNEL],
  output logic [SEL_WIDTH-1:0]  sel,
  output logic [CHANNEL-1:0]    wr_cmd_vld,
  output logic [CHANNEL-1:0]    rd_cmd_vld,
  output logic [ADDR_WIDTH-1:0] addr_out [CHANNEL],
  output logic [DATA_WIDTH-1:0] wr_data_out [CHANNEL],
  input  logic [DATA_WIDTH-1:0] bank_rd_data,
  output logic [CHANNEL-1:0]    rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  ptr_nxt;
  logic [CHANNEL-1:0]    cand;
  logic [CHANNEL-1:0]    grant_oh;
  logic                  grant_any;
  logic [SEL_WIDTH-1:0]  grant_id;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [RD_LATENCY-1:0] tag_vld;
  logic [SEL_WIDTH-1:0]  tag_id [RD_LATENCY];

  // Reset also masks candidates so nothing is accepted while the block is held in reset.
  assign cand = req_vld & {CHANNEL{arb_en & ~rst}};

  always_comb begin
    int                   pos;
    logic [SEL_WIDTH-1:0] idx;
    grant_any = 1'b0;
    grant_id  = '0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < CHANNEL; i++) begin
      pos = int'(ptr) + i;
      if (pos >= CHANNEL) pos = pos - CHANNEL;
      idx = SEL_WIDTH'(pos);
      if (!grant_any && cand[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign grant_oh = grant_any ? (CHANNEL'(1) << grant_id) : '0;
  assign req_rdy  = grant_oh;
  assign ptr_nxt  = (grant_id == SEL_WIDTH'(CHANNEL - 1)) ? '0 : grant_id + SEL_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      wr_cmd_vld <= '0;
      rd_cmd_vld <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (grant_any) begin
      sel        <= grant_id;
      addr_q     <= req_addr[grant_id];
      wdata_q    <= req_wdata[grant_id];
      wr_cmd_vld <= req_wr[grant_id] ? grant_oh : '0;
      rd_cmd_vld <= req_wr[grant_id] ? '0 : grant_oh;
    end else begin
      wr_cmd_vld <= '0;
      rd_cmd_vld <= '0;
    end
  end

  // The bank sees a single shared address/data bus; every entry carries the same value.
  always_comb begin
    for (int i = 0; i < CHANNEL; i++) begin
      addr_out[i]    = addr_q;
      wr_data_out[i] = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= |rd_cmd_vld;
      tag_id[0]  <= sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
    end else if (tag_vld[RD_LATENCY-1]) begin
      rsp_vld  <= CHANNEL'(1) << tag_id[RD_LATENCY-1];
      rsp_data <= bank_rd_data;
    end else begin
      rsp_vld <= '0;
    end
  end

endmodule

// File: tb/tb_sram_bank_req_arb.sv
// Bench for sram_bank_req_arb: directed scenarios plus randomized traffic checked
// against a cycle-indexed event log of grants, reads and bank data.
module tb_sram_bank_req_arb;

  localparam int CH = 8;
  localparam int SW = 3;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int L  = 1;
  localparam int MAXCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          arb_en;
  logic [CH-1:0] req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr [CH];
  logic [DW-1:0] req_wdata [CH];
  logic [SW-1:0] sel;
  logic [CH-1:0] wr_cmd_vld, rd_cmd_vld, rsp_vld;
  logic [AW-1:0] addr_out [CH];
  logic [DW-1:0] wr_data_out [CH];
  logic [DW-1:0] bank_rd_data, rsp_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state: pointer, grant of the current cycle, expected registered outputs
  int            m_ptr = 0;
  int            m_grant = -1;
  int            last_rst = -1;
  logic [CH-1:0] e_rdy = '0, e_wr = '0, e_rd = '0, e_rsp_vld = '0;
  logic [SW-1:0] e_sel = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rsp_data = '0;
  int            rd_log [MAXCYC];
  logic [DW-1:0] bank_log [MAXCYC];

  sram_bank_req_arb #(.CHANNEL(CH), .SEL_WIDTH(SW), .DATA_WIDTH(DW),
                      .ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .sel(sel), .wr_cmd_vld(wr_cmd_vld), .rd_cmd_vld(rd_cmd_vld),
    .addr_out(addr_out), .wr_data_out(wr_data_out),
    .bank_rd_data(bank_rd_data), .rsp_vld(rsp_vld), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Round-robin winner for this cycle from the current inputs
  task automatic model_eval();
    logic [SW-1:0] idx;
    m_grant = -1;
    if (!rst && arb_en) begin
      for (int k = 0; k < CH; k++) begin
        idx = SW'((m_ptr + k) % CH);
        if (m_grant < 0 && req_vld[idx]) m_grant = int'(idx);
      end
    end
    e_rdy = (m_grant >= 0) ? (CH'(1) << m_grant) : '0;
  endtask

  // Expected registered outputs for the next cycle; a read accepted in cycle N answers
  // in N+2+L with the bank data of cycle N+1+L unless reset hit in between.
  task automatic model_commit();
    logic [SW-1:0] gi;
    int            src;
    rd_log[cyc] = -1;
    if (rst) begin
      m_ptr = 0; e_sel = '0; e_wr = '0; e_rd = '0; e_addr = '0; e_wdata = '0;
      e_rsp_vld = '0; e_rsp_data = '0; last_rst = cyc;
    end else begin
      if (m_grant >= 0) begin
        gi      = SW'(m_grant);
        e_sel   = gi;
        e_addr  = req_addr[gi];
        e_wdata = req_wdata[gi];
        e_wr    = req_wr[gi] ? e_rdy : '0;
        e_rd    = req_wr[gi] ? '0 : e_rdy;
        m_ptr   = (m_grant + 1) % CH;
        if (!req_wr[gi]) rd_log[cyc] = m_grant;
      end else begin
        e_wr = '0; e_rd = '0;
      end
      src = cyc - 1 - L;
      if (src >= 0 && rd_log[src] >= 0 && last_rst < src) begin
        e_rsp_vld  = CH'(1) << rd_log[src];
        e_rsp_data = bank_log[cyc];
      end else begin
        e_rsp_vld = '0;
      end
    end
  endtask

  task automatic settle();
    bank_log[cyc] = bank_rd_data;
    model_eval();
    #1;
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXCYC) begin
      $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXCYC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    bank_rd_data = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0;
    for (int i = 0; i < 2; i++) begin settle(); advance(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_en = 1'b1; req_vld = '1; req_wr = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++;
      if (req_rdy !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rdy got=%h exp=00", req_rdy); end
      vectors++;
      if (sel !== 3'd0 || wr_cmd_vld !== 8'h00 || rd_cmd_vld !== 8'h00 || rsp_vld !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_ctl got sel=%0d wr=%h rd=%h rsp=%h exp all zero", sel, wr_cmd_vld, rd_cmd_vld, rsp_vld);
      end
      vectors++;
      if (addr_out[5] !== 11'h0 || wr_data_out[2] !== 32'h0 || rsp_data !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_data got addr=%h wdata=%h rsp=%h exp zero", addr_out[5], wr_data_out[2], rsp_data);
      end
      advance();
    end
    rst = 1'b0; req_vld = '0;
  endtask

  task automatic test_single_read();
    req_vld = 8'h08; req_wr = '0; req_addr[3] = 11'h010;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bank_rd_data = 32'hDEAD_BEEF;
      settle();
      if (i == 0) begin
        vectors++;
        if (req_rdy !== 8'h08) begin miscompares++; $display("[TB] FAIL rd_rdy got=%h exp=08", req_rdy); end
      end
      if (i == 1) begin
        vectors++;
        if (rd_cmd_vld !== 8'h08 || sel !== 3'd3 || addr_out[0] !== 11'h010 || addr_out[7] !== 11'h010) begin
          miscompares++;
          $display("[TB] FAIL rd_cmd got rd=%h sel=%0d addr=%h exp 08/3/010", rd_cmd_vld, sel, addr_out[0]);
        end
      end
      if (i == 3) begin
        vectors++;
        if (rsp_vld !== 8'h08 || rsp_data !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("[TB] FAIL rd_rsp got vld=%h data=%h exp 08/deadbeef", rsp_vld, rsp_data);
        end
      end else begin
        vectors++;
        if (rsp_vld !== 8'h00) begin miscompares++; $display("[TB] FAIL rd_rsp_idle i=%0d got=%h exp=00", i, rsp_vld); end
      end
      advance();
      req_vld = '0;
    end
  endtask

  task automatic test_round_robin();
    int            cnt [CH];
    logic [CH-1:0] exp;
    do_reset();
    for (int c = 0; c < CH; c++) begin cnt[c] = 0; req_addr[c] = AW'($urandom); end
    req_vld = '1; req_wr = '0;
    for (int i = 0; i < 16; i++) begin
      settle();
      exp = CH'(1) << (i % CH);
      vectors++;
      if (req_rdy !== exp) begin miscompares++; $display("[TB] FAIL rr_order i=%0d got=%h exp=%h", i, req_rdy, exp); end
      vectors++;
      if ($countones(req_rdy) != 1) begin miscompares++; $display("[TB] FAIL rr_onehot i=%0d got=%h exp one bit", i, req_rdy); end
      for (int c = 0; c < CH; c++) if (req_rdy[c]) cnt[c]++;
      vectors++;
      if (rsp_vld !== e_rsp_vld || rsp_data !== e_rsp_data) begin
        miscompares++;
        $display("[TB] FAIL rr_rsp i=%0d got=%h/%h exp=%h/%h", i, rsp_vld, rsp_data, e_rsp_vld, e_rsp_data);
      end
      advance();
    end
    req_vld = '0;
    for (int c = 0; c < CH; c++) begin
      vectors++;
      if (cnt[c] != 2) begin miscompares++; $display("[TB] FAIL rr_count ch=%0d got=%0d exp=2", c, cnt[c]); end
    end
  endtask

  task automatic test_write();
    req_vld = 8'h04; req_wr = 8'h04; req_addr[2] = 11'h7FF; req_wdata[2] = 32'h1234_5678;
    settle(); advance();
    req_vld = '0; req_wr = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (i == 0) begin
        vectors++;
        if (wr_cmd_vld !== 8'h04 || rd_cmd_vld !== 8'h00 || wr_data_out[6] !== 32'h1234_5678 || addr_out[1] !== 11'h7FF) begin
          miscompares++;
          $display("[TB] FAIL wr_cmd got wr=%h rd=%h data=%h addr=%h exp 04/00/12345678/7ff",
                   wr_cmd_vld, rd_cmd_vld, wr_data_out[6], addr_out[1]);
        end
      end else begin
        vectors++;
        if (rsp_vld !== e_rsp_vld) begin miscompares++; $display("[TB] FAIL wr_rsp i=%0d got=%h exp=%h", i, rsp_vld, e_rsp_vld); end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int            a;
    logic [CH-1:0] seq [3];
    seq[0] = 8'h02; seq[1] = 8'h20; seq[2] = 8'h02;
    req_wr = '0; req_addr[1] = 11'h111; req_addr[5] = 11'h555;
    a = cyc;
    for (int i = 0; i < 7; i++) begin
      req_vld = (i < 3) ? seq[i] : '0;
      settle();
      if (i >= 3 && i <= 5) begin
        vectors++;
        if (rsp_vld !== seq[i-3] || rsp_data !== bank_log[a + i - 1]) begin
          miscompares++;
          $display("[TB] FAIL b2b_rsp i=%0d got=%h/%h exp=%h/%h", i, rsp_vld, rsp_data, seq[i-3], bank_log[a + i - 1]);
        end
      end else begin
        vectors++;
        if (rsp_vld !== 8'h00) begin miscompares++; $display("[TB] FAIL b2b_idle i=%0d got=%h exp=00", i, rsp_vld); end
      end
      advance();
    end
    req_vld = '0;
  endtask

  task automatic test_arb_disable();
    req_vld = 8'h20; req_wr = 8'h20; arb_en = 1'b1;
    settle(); advance();
    req_vld = 8'h41; req_wr = 8'h41; arb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      vectors++;
      if (req_rdy !== 8'h00) begin miscompares++; $display("[TB] FAIL dis_rdy i=%0d got=%h exp=00", i, req_rdy); end
      if (i > 0) begin
        vectors++;
        if (wr_cmd_vld !== 8'h00 || rd_cmd_vld !== 8'h00) begin
          miscompares++; $display("[TB] FAIL dis_cmd i=%0d got=%h/%h exp=00/00", i, wr_cmd_vld, rd_cmd_vld);
        end
      end
      advance();
    end
    arb_en = 1'b1;
    settle();
    vectors++;
    if (req_rdy !== 8'h40) begin miscompares++; $display("[TB] FAIL en_first got=%h exp=40", req_rdy); end
    advance();
    req_vld = 8'h01;
    settle();
    vectors++;
    if (req_rdy !== 8'h01) begin miscompares++; $display("[TB] FAIL en_second got=%h exp=01", req_rdy); end
    advance();
    req_vld = '0; req_wr = '0;
  endtask

  task automatic test_reset_mid_read();
    req_vld = 8'h10; req_wr = '0; req_addr[4] = 11'h0AB;
    settle(); advance();
    req_vld = '0;
    settle();
    vectors++;
    if (rd_cmd_vld !== 8'h10) begin miscompares++; $display("[TB] FAIL mid_cmd got=%h exp=10", rd_cmd_vld); end
    advance();
    rst = 1'b1; req_vld = 8'h02;
    settle();
    vectors++;
    if (req_rdy !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rdy got=%h exp=00", req_rdy); end
    advance();
    rst = 1'b0; req_vld = '0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (i == 0) begin
        vectors++;
        if (rd_cmd_vld !== 8'h00 || wr_cmd_vld !== 8'h00 || sel !== 3'd0 || addr_out[4] !== 11'h0) begin
          miscompares++;
          $display("[TB] FAIL mid_clear got rd=%h wr=%h sel=%0d addr=%h exp zero", rd_cmd_vld, wr_cmd_vld, sel, addr_out[4]);
        end
      end
      vectors++;
      if (rsp_vld !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rsp i=%0d got=%h exp=00", i, rsp_vld); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] gi;
    for (int n = 0; n < 320; n++) begin
      rst    = (n < 300) && ($urandom_range(0, 49) == 0);
      arb_en = (n < 300) && ($urandom_range(0, 9) != 0);
      for (int c = 0; c < CH; c++) begin
        if (n < 300 && !req_vld[c] && $urandom_range(0, 1) == 1) begin
          req_vld[c] = 1'b1; req_wr[c] = 1'($urandom);
          req_addr[c] = AW'($urandom); req_wdata[c] = $urandom;
        end
      end
      settle();
      vectors++;
      if (req_rdy !== e_rdy) begin miscompares++; $display("[TB] FAIL rand_rdy n=%0d got=%h exp=%h", n, req_rdy, e_rdy); end
      vectors++;
      if (sel !== e_sel || wr_cmd_vld !== e_wr || rd_cmd_vld !== e_rd) begin
        miscompares++;
        $display("[TB] FAIL rand_cmd n=%0d got=%0d/%h/%h exp=%0d/%h/%h", n, sel, wr_cmd_vld, rd_cmd_vld, e_sel, e_wr, e_rd);
      end
      for (int c = 0; c < CH; c++) begin
        vectors++;
        if (addr_out[c] !== e_addr || wr_data_out[c] !== e_wdata) begin
          miscompares++;
          $display("[TB] FAIL rand_bus n=%0d ch=%0d got=%h/%h exp=%h/%h", n, c, addr_out[c], wr_data_out[c], e_addr, e_wdata);
        end
      end
      vectors++;
      if (rsp_vld !== e_rsp_vld || rsp_data !== e_rsp_data) begin
        miscompares++;
        $display("[TB] FAIL rand_rsp n=%0d got=%h/%h exp=%h/%h", n, rsp_vld, rsp_data, e_rsp_vld, e_rsp_data);
      end
      advance();
      if (m_grant >= 0) begin
        gi = SW'(m_grant);
        req_vld[gi] = 1'b0;
      end
    end
    rst = 1'b0; req_vld = '0; arb_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MAXCYC; i++) begin rd_log[i] = -1; bank_log[i] = '0; end
    rst = 1'b1; arb_en = 1'b1; req_vld = '0; req_wr = '0; bank_rd_data = '0;
    for (int c = 0; c < CH; c++) begin req_addr[c] = '0; req_wdata[c] = '0; end
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_back_to_back();
    test_arb_disable();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_bank_req_arb.md
Name: sram_bank_req_arb

Overview:
- Request front end placed directly upstream of the SRAM bank wrapper.
- Takes up to CHANNEL independent read/write requests, each with a valid/ready handshake.
- Picks one request per cycle by round-robin and drives the bank's sel, one-hot cmd valids, address and write data.
- Tracks issued reads through a fixed-latency tag pipeline and routes returning read data back to the requesting channel.

Parameters:
- CHANNEL, 8, number of requesting channels
- SEL_WIDTH, $clog2(CHANNEL), width of sel / channel id
- DATA_WIDTH, 32, read/write data width
- ADDR_WIDTH, 11, SRAM word address width
- RD_LATENCY, 1, cycles from bank rd_cmd_vld to valid bank read data (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- arb_en  in  1  1 = grants allowed; 0 = no new grants
- req_vld  in  CHANNEL  per-channel request valid
- req_rdy  out  CHANNEL  per-channel request accepted this cycle
- req_wr  in  CHANNEL  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH x [CHANNEL]  request address
- req_wdata  in  DATA_WIDTH x [CHANNEL]  write data
- sel  out  SEL_WIDTH  channel id of the current bank command
- wr_cmd_vld  out  CHANNEL  one-hot write command to bank
- rd_cmd_vld  out  CHANNEL  one-hot read command to bank
- addr_out  out  ADDR_WIDTH x [CHANNEL]  command address, same value on all entries
- wr_data_out  out  DATA_WIDTH x [CHANNEL]  write data, same value on all entries
- bank_rd_data  in  DATA_WIDTH  read data from bank, valid RD_LATENCY cycles after rd_cmd_vld
- rsp_vld  out  CHANNEL  one-hot read response valid
- rsp_data  out  DATA_WIDTH  read response data, shared by all channels

Behaviour:
- Reset values:
  - Round-robin pointer = 0.
  - sel = 0; wr_cmd_vld, rd_cmd_vld, rsp_vld = 0.
  - addr_out, wr_data_out, rsp_data = 0.
  - Tag pipeline cleared, so in-flight reads are discarded.
  - req_rdy = 0 while rst = 1.
- Arbitration (combinational in cycle N):
  - Candidates are req_vld & {CHANNEL{arb_en}}.
  - Search starts at pointer p and wraps modulo CHANNEL; the first set channel g wins.
  - req_rdy = one-hot(g) when any candidate exists, otherwise 0.
  - Handshake completes when req_vld[g] & req_rdy[g].
  - Requesters must hold vld, wr, addr and wdata stable until accepted.
- Pointer update:
  - On a grant, pointer <= (g+1) mod CHANNEL.
  - With no grant, the pointer holds.
- Command register (visible cycle N+1):
  - On grant: sel <= g; addr_out[*] <= req_addr[g]; wr_data_out[*] <= req_wdata[g].
  - wr_cmd_vld <= one-hot(g) if req_wr[g], else 0.
  - rd_cmd_vld <= one-hot(g) if !req_wr[g], else 0.
  - With no grant, both cmd valids go to 0. sel, addr_out and wr_data_out hold their last values.
  - Exactly one command at most per cycle; wr_cmd_vld and rd_cmd_vld are never both nonzero.
- Read tag pipeline:
  - Depth RD_LATENCY, shift every cycle.
  - Stage 0 loads {valid = |rd_cmd_vld, id = sel}.
  - When the final stage is valid: rsp_vld <= one-hot(id) and rsp_data <= bank_rd_data, registered.
  - Otherwise rsp_vld <= 0 and rsp_data holds.
- Latency:
  - Read accept in cycle N: bank cmd at N+1, response at N+2+RD_LATENCY, i.e. N+3 for RD_LATENCY = 1.
  - Writes produce no response.
- Throughput: one accepted request per cycle; back-to-back reads yield back-to-back responses in issue order.
- There is no response backpressure. Consumers must always sink rsp_vld.
- arb_en = 0:
  - req_rdy = 0 and the pointer holds.
  - Already-issued reads still return.
- Simultaneous events:
  - A grant and a response in the same cycle are independent.
  - Reset asserted mid-read drops that response; no rsp_vld appears after reset deassertion.
- Boundaries:
  - Pointer wraps from CHANNEL-1 to 0.
  - A single persistent requester is granted every cycle.

Test Plan:
- Reset, then ch3 read addr 0x010 at cycle 5 -> rd_cmd_vld = 8'h08, sel = 3, addr_out = 0x010 at cycle 6. With the bank returning 0xDEAD_BEEF, rsp_vld = 8'h08 and rsp_data = 0xDEAD_BEEF at cycle 8.
- All 8 channels hold req_vld for 16 cycles, pointer 0 -> grant order 0,1,…,7,0,…,7. Each channel gets exactly 2 grants and every req_rdy is one-hot.
- ch2 write 0x1234_5678 to 0x7FF -> wr_cmd_vld = 8'h04, wr_data_out[*] = 0x1234_5678, rd_cmd_vld = 0, and no rsp_vld follows.
- Reads from ch1, ch5, ch1 in consecutive cycles -> rsp_vld sequence 8'h02, 8'h20, 8'h02 on consecutive cycles, each carrying its data.
- arb_en = 0 for 4 cycles with ch0/ch6 requesting -> req_rdy = 0 and no cmd valids. Re-enable with pointer = 6 -> ch6 is granted first, then ch0.
- Assert rst one cycle after a read issues -> cmd and tag state clear, and rsp_vld stays 0 for 5 cycles after reset release.
